// File: rtl/nt_sig_pkg.sv
// rtl/nt_sig_pkg.sv - shared state encoding, default polynomials/seed and the Galois step function
package nt_sig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] DEF_LFSR_POLY = 16'h002D;
  localparam logic [15:0] DEF_MISR_POLY = 16'h002D;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Width-generic Galois shift: callers size-cast the result down to their own register width.
  function automatic logic [63:0] lfsr_step(input logic [63:0] value,
                                            input logic [63:0] poly,
                                            input int          width);
    logic [63:0] mask;
    logic [63:0] nxt;
    mask = (64'd1 << width) - 64'd1;
    nxt  = (value << 1) ^ (value[width-1] ? poly : 64'd0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/nt_misr.sv
// rtl/nt_misr.sv - single-input MISR compacting one response bit per enabled cycle
module nt_misr
  import nt_sig_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_MISR_POLY)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = SIG_W'(lfsr_step(64'(sig), 64'(POLY), SIG_W)) ^ SIG_W'(din);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= sig_d;
    end
  end

endmodule

// File: rtl/nt_subckt_sig_checker.sv
// rtl/nt_subckt_sig_checker.sv - LFSR stimulus / MISR signature self-test wrapper for one subcircuit
module nt_subckt_sig_checker
  import nt_sig_pkg::*;
#(
  parameter int                N_IN      = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DEF_LFSR_POLY),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEF_LFSR_SEED),
  parameter int                SIG_W     = 16,
  parameter logic [SIG_W-1:0]  MISR_POLY = SIG_W'(DEF_MISR_POLY),
  parameter int                PIPE_LAT  = 2,
  parameter int                WINDOW    = 1000
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             resp,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             mismatch
);

  localparam int CNT_MAX = (WINDOW > PIPE_LAT) ? WINDOW : PIPE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [SIG_W-1:0]  golden_q;
  logic [SIG_W-1:0]  misr_q;
  logic [SIG_W-1:0]  misr_d;
  logic [N_IN-1:0]   stim_q;
  logic              busy_q;
  logic              done_q;
  logic [SIG_W-1:0]  signature_q;
  logic              mismatch_q;
  logic              accept;
  logic              misr_en;

  assign accept  = (state_q == IDLE) && start;
  assign misr_en = (state_q == RUN);

  nt_misr #(
    .SIG_W (SIG_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk_i  (I1470),
    .rst_i  (I1477),
    .clear  (accept),
    .enable (misr_en),
    .din    (resp),
    .sig    (misr_q)
  );

  // misr_d mirrors what the MISR will hold after this edge, so the final sample lands in signature.
  always_comb begin
    lfsr_d = LFSR_W'(lfsr_step(64'(lfsr_q), 64'(LFSR_POLY), LFSR_W));
    misr_d = SIG_W'(lfsr_step(64'(misr_q), 64'(MISR_POLY), SIG_W)) ^ SIG_W'(resp);
  end

  always_ff @(posedge I1470) begin
    if (I1477) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= '0;
      golden_q    <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      signature_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stim_q <= '0;
          busy_q <= 1'b0;
          if (start) begin
            lfsr_q      <= SEED_EFF;
            cnt_q       <= '0;
            golden_q    <= golden_sig;
            signature_q <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b1;
            stim_q      <= SEED_EFF[N_IN-1:0];
            state_q     <= (PIPE_LAT == 0) ? RUN : FLUSH;
          end
        end
        FLUSH: begin
          lfsr_q <= lfsr_d;
          stim_q <= lfsr_d[N_IN-1:0];
          if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          lfsr_q <= lfsr_d;
          if (cnt_q == CNT_W'(WINDOW - 1)) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            stim_q      <= '0;
            signature_q <= misr_d;
            mismatch_q  <= (misr_d != golden_q);
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            stim_q <= lfsr_d[N_IN-1:0];
          end
        end
        DONE: begin
          stim_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = signature_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_nt_subckt_sig_checker.sv
// tb/tb_nt_subckt_sig_checker.sv - two-configuration bench with a time-indexed reference model
module tb_nt_subckt_sig_checker;

  logic        clk = 1'b0;
  logic        rst, start, resp;
  logic [15:0] golden;

  logic [3:0]  stim_a, stim_b;
  logic        busy_a, busy_b, done_a, done_b, mm_a, mm_b;
  logic [15:0] sig_a, sig_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nt_subckt_sig_checker #(
    .N_IN(4), .LFSR_W(16), .LFSR_POLY(16'h002D), .LFSR_SEED(16'hACE1),
    .SIG_W(16), .MISR_POLY(16'h002D), .PIPE_LAT(2), .WINDOW(4)
  ) dut_a (
    .I1470(clk), .I1477(rst), .start(start), .golden_sig(golden), .resp(resp),
    .stim(stim_a), .busy(busy_a), .done(done_a), .signature(sig_a), .mismatch(mm_a)
  );

  nt_subckt_sig_checker #(
    .N_IN(4), .LFSR_W(16), .LFSR_POLY(16'h002D), .LFSR_SEED(16'h0000),
    .SIG_W(16), .MISR_POLY(16'h002D), .PIPE_LAT(0), .WINDOW(3)
  ) dut_b (
    .I1470(clk), .I1477(rst), .start(start), .golden_sig(golden), .resp(resp),
    .stim(stim_b), .busy(busy_b), .done(done_b), .signature(sig_b), .mismatch(mm_b)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], 1'b0} ^ (v[15] ? 16'h002D : 16'h0000);
  endfunction

  // Reference model: each run is described by its accept edge; outputs follow from the offset.
  bit          rh [0:2047];
  int          cyc = 0;
  bit          mvalid = 0;
  int          pl [2] = '{2, 0};
  int          wl [2] = '{4, 3};
  logic [15:0] sd [2] = '{16'hACE1, 16'h0000};
  bit          act [2] = '{0, 0};
  int          st [2] = '{-100, -100};
  logic [15:0] gl [2];
  logic [15:0] e_sig [2] = '{16'h0, 16'h0};
  bit          e_mm [2], e_busy [2], e_done [2];
  logic [3:0]  e_stim [2];
  int          md;
  logic [15:0] mv;

  function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int d);
    logic [15:0] v;
    v = (seed == 16'h0) ? 16'h0001 : seed;
    for (int i = 0; i < d; i++) v = step(v);
    return v;
  endfunction

  function automatic logic [15:0] fold(input int s, input int p, input int w);
    logic [15:0] m;
    m = 16'h0;
    for (int j = 1; j <= w; j++) m = step(m) ^ {15'b0, rh[s+p+j]};
    return m;
  endfunction

  always @(posedge clk) begin
    if (cyc < 2047) cyc++;
    rh[cyc] = resp;
    if (rst) mvalid = 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 0; st[i] = -100; e_sig[i] = 16'h0; e_mm[i] = 0;
      end else if (!act[i] && start && (cyc >= st[i] + pl[i] + wl[i] + 2)) begin
        act[i] = 1; st[i] = cyc; gl[i] = golden; e_sig[i] = 16'h0; e_mm[i] = 0;
      end
      e_busy[i] = 0; e_done[i] = 0; e_stim[i] = 4'h0;
      if (act[i]) begin
        md = cyc - st[i];
        if (md < pl[i] + wl[i]) begin
          e_busy[i] = 1;
          mv = lfsr_at(sd[i], md);
          e_stim[i] = mv[3:0];
        end else begin
          e_done[i] = 1;
          e_sig[i] = fold(st[i], pl[i], wl[i]);
          e_mm[i] = (e_sig[i] != gl[i]);
          act[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("cmp_busy_a", 16'(busy_a), 16'(e_busy[0]));
      chk("cmp_done_a", 16'(done_a), 16'(e_done[0]));
      chk("cmp_stim_a", 16'(stim_a), 16'(e_stim[0]));
      chk("cmp_sig_a",  sig_a,       e_sig[0]);
      chk("cmp_mm_a",   16'(mm_a),   16'(e_mm[0]));
      chk("cmp_busy_b", 16'(busy_b), 16'(e_busy[1]));
      chk("cmp_done_b", 16'(done_b), 16'(e_done[1]));
      chk("cmp_stim_b", 16'(stim_b), 16'(e_stim[1]));
      chk("cmp_sig_b",  sig_b,       e_sig[1]);
      chk("cmp_mm_b",   16'(mm_b),   16'(e_mm[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int          r_dn, r_ndone, r_nbusy, r_bdn, r_d2;
  logic        r_mm, r_busy1, r_b8, r_b9;
  logic [15:0] r_sg;
  logic [3:0]  r_s1, r_s2, r_b1;

  // mode 0: resp all zero, 1: all one, 2: one only while A flushes
  task automatic run_a(input logic [15:0] g, input int mode);
    golden = g; start = 1; resp = (mode == 1); tick(); start = 0;
    r_dn = 0; r_ndone = 0; r_nbusy = 0; r_bdn = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 1) begin r_s1 = stim_a; r_b1 = stim_b; r_busy1 = busy_a; end
      if (n == 2) r_s2 = stim_a;
      if (busy_a) r_nbusy++;
      if (done_a) begin r_ndone++; r_dn = n; r_sg = sig_a; r_mm = mm_a; end
      if (done_b && r_bdn == 0) r_bdn = n;
      resp = (mode == 1) || (mode == 2 && n <= 2);
      tick();
    end
    resp = 0;
  endtask

  initial begin
    rst = 1; start = 0; resp = 0; golden = 16'h0;
    repeat (3) tick();
    rst = 0; tick();
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_done", 16'(done_a), 16'h0);
    chk("rst_sig",  sig_a,       16'h0);
    chk("rst_mm",   16'(mm_a),   16'h0);
    chk("rst_stim", 16'(stim_a), 16'h0);

    run_a(16'h0000, 0);
    chk("zero_done_at",  16'(r_dn),     16'd7);
    chk("zero_ndone",    16'(r_ndone),  16'd1);
    chk("zero_nbusy",    16'(r_nbusy),  16'd6);
    chk("zero_busy1",    16'(r_busy1),  16'd1);
    chk("zero_sig",      r_sg,          16'h0000);
    chk("zero_mm",       16'(r_mm),     16'd0);
    chk("stim_flush1",   16'(r_s1),     16'h1);
    chk("stim_flush2",   16'(r_s2),     16'hF);
    chk("seed0_stim",    16'(r_b1),     16'h1);
    chk("b_done_at",     16'(r_bdn),    16'd4);

    run_a(16'h000F, 1);
    chk("ones_done_at", 16'(r_dn), 16'd7);
    chk("ones_sig",     r_sg,      16'h000F);
    chk("ones_mm",      16'(r_mm), 16'd0);
    run_a(16'h000E, 1);
    chk("ones_sig_e",   r_sg,      16'h000F);
    chk("ones_mm_e",    16'(r_mm), 16'd1);
    run_a(16'h0000, 2);
    chk("flush_sig",    r_sg,      16'h0000);
    chk("flush_mm",     16'(r_mm), 16'd0);

    golden = 16'h0; start = 1; tick(); start = 0; resp = 1;
    for (int n = 1; n <= 4; n++) tick();
    rst = 1; tick(); rst = 0;
    chk("midrst_busy", 16'(busy_a), 16'h0);
    chk("midrst_sig",  sig_a,       16'h0);
    chk("midrst_done", 16'(done_a), 16'h0);
    r_ndone = 0;
    for (int n = 0; n < 10; n++) begin
      if (done_a) r_ndone++;
      tick();
    end
    chk("midrst_nodone", 16'(r_ndone), 16'd0);
    run_a(16'h000F, 1);
    chk("after_rst_done_at", 16'(r_dn), 16'd7);
    chk("after_rst_sig",     r_sg,      16'h000F);

    golden = 16'h1234; start = 1; tick(); start = 0;
    r_ndone = 0; r_dn = 0;
    for (int n = 1; n <= 12; n++) begin
      if (done_a) begin r_ndone++; r_dn = n; end
      if (n == 8) r_b8 = busy_a;
      if (n == 9) r_b9 = busy_a;
      start = (n == 3) || (n == 7);
      resp = $urandom_range(0, 1);
      tick();
    end
    start = 0; resp = 0;
    chk("ign_ndone",   16'(r_ndone), 16'd1);
    chk("ign_done_at", 16'(r_dn),    16'd7);
    chk("ign_busy8",   16'(r_b8),    16'd0);
    chk("ign_busy9",   16'(r_b9),    16'd0);
    repeat (6) tick();

    start = 1; tick();
    r_ndone = 0; r_dn = 0; r_d2 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (done_a) begin
        r_ndone++;
        if (r_dn == 0) r_dn = n; else r_d2 = n;
      end
      if (n == 8) r_b8 = busy_a;
      if (n == 9) r_b9 = busy_a;
      start = (n < 20);
      tick();
    end
    start = 0;
    chk("held_done1", 16'(r_dn),    16'd7);
    chk("held_done2", 16'(r_d2),    16'd15);
    chk("held_ndone", 16'(r_ndone), 16'd2);
    chk("held_busy8", 16'(r_b8),    16'd0);
    chk("held_busy9", 16'(r_b9),    16'd1);
    repeat (12) tick();

    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      start  = ($urandom_range(0, 3) == 0);
      resp   = $urandom_range(0, 1);
      golden = ($urandom_range(0, 3) == 0) ? 16'h000F : 16'($urandom);
      tick();
    end
    rst = 0; start = 0; resp = 0;
    repeat (15) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
